// File: rtl/ssd_pkg.sv
// Shared definitions for the seven-segment display logic.
//   - state_e    : scan arbiter FSM state encoding
//   - CATH_BLANK : cathode pattern with every segment off (active-low)
//   - AN_OFF     : anode pattern with every digit off (active-low)
//   - cnt_w()    : counter width for a modulus, never less than 1 bit
package ssd_pkg;

  typedef enum logic [1:0] {
    ST_NORMAL   = 2'd0,
    ST_MSG_WAIT = 2'd1,
    ST_MSG_SHOW = 2'd2
  } state_e;

  localparam logic [6:0] CATH_BLANK = 7'h7F;
  localparam logic [7:0] AN_OFF     = 8'hFF;

  function automatic int unsigned cnt_w(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/hex_to_ssd.sv
// Combinational hex nibble to seven-segment decoder.
// Ports:
//   i_nib  : 4-bit value 0..F
//   o_cath : {Ca..Cg}, active-low segment drive
module hex_to_ssd (
  input  logic [3:0] i_nib,
  output logic [6:0] o_cath
);

  always_comb begin
    o_cath = 7'b1111111;
    case (i_nib)
      4'h0: o_cath = 7'b0000001;
      4'h1: o_cath = 7'b1001111;
      4'h2: o_cath = 7'b0010010;
      4'h3: o_cath = 7'b0000110;
      4'h4: o_cath = 7'b1001100;
      4'h5: o_cath = 7'b0100100;
      4'h6: o_cath = 7'b0100000;
      4'h7: o_cath = 7'b0001111;
      4'h8: o_cath = 7'b0000000;
      4'h9: o_cath = 7'b0000100;
      4'hA: o_cath = 7'b0001000;
      4'hB: o_cath = 7'b1100000;
      4'hC: o_cath = 7'b0110001;
      4'hD: o_cath = 7'b1000010;
      4'hE: o_cath = 7'b0110000;
      4'hF: o_cath = 7'b0111000;
      default: o_cath = 7'b1111111;
    endcase
  end

endmodule

// File: rtl/ssd_scan_arbiter.sv
// Scan controller for an 8-digit seven-segment display shared between a
// normal status source and a message source that temporarily overrides it
// for MSG_FRAMES scan frames.
// Ports:
//   Clk, reset          : clock, asynchronous active-low reset
//   norm_data/en/blink  : normal digits (nibble per digit), enables, blink enables
//   msg_req/data/en     : message request (level), digits, enables
//   msg_ack             : one-cycle pulse when a message is latched
//   msg_busy            : message pending or on display
//   digit_idx           : digit currently scanned
//   An, Cath, Dp        : active-low anodes, cathodes {Ca..Cg}, decimal point
module ssd_scan_arbiter
  import ssd_pkg::*;
#(
  parameter int unsigned SCAN_DIV     = 262144,
  parameter int unsigned BLINK_FRAMES = 24,
  parameter int unsigned MSG_FRAMES   = 32
) (
  input  logic        Clk,
  input  logic        reset,
  input  logic [31:0] norm_data,
  input  logic [7:0]  norm_en,
  input  logic [7:0]  norm_blink,
  input  logic        msg_req,
  input  logic [31:0] msg_data,
  input  logic [7:0]  msg_en,
  output logic        msg_ack,
  output logic        msg_busy,
  output logic [2:0]  digit_idx,
  output logic [7:0]  An,
  output logic [6:0]  Cath,
  output logic        Dp
);

  localparam int unsigned PW = cnt_w(SCAN_DIV);
  localparam int unsigned BW = cnt_w(BLINK_FRAMES);
  localparam int unsigned MW = cnt_w(MSG_FRAMES);
  localparam logic [PW-1:0] PRESC_LAST = PW'(SCAN_DIV - 1);
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_FRAMES - 1);
  localparam logic [MW-1:0] MSG_LAST   = MW'(MSG_FRAMES - 1);

  logic [PW-1:0] r_presc;
  logic [2:0]    r_digit;
  logic [BW-1:0] r_blink_cnt;
  logic          r_blink_phase;
  logic [MW-1:0] r_msg_cnt;
  state_e        r_state;
  state_e        w_state_nxt;
  logic [31:0]   r_msg_data;
  logic [7:0]    r_msg_en;
  logic          r_ack;
  logic [7:0]    r_an;
  logic [6:0]    r_cath;

  logic          w_tick;
  logic          w_frame_end;
  logic          w_accept;
  logic          w_show_msg;
  logic          w_busy;
  logic [31:0]   w_src_data;
  logic [7:0]    w_src_en;
  logic [3:0]    w_nib;
  logic          w_blank;
  logic [6:0]    w_hex;

  assign w_tick      = (r_presc == PRESC_LAST);
  assign w_frame_end = w_tick && (r_digit == 3'd7);

  // Prescaler and digit sequencing
  always_ff @(posedge Clk or negedge reset) begin
    if (!reset) begin
      r_presc <= '0;
      r_digit <= '0;
    end else if (w_tick) begin
      r_presc <= '0;
      r_digit <= r_digit + 3'd1;
    end else begin
      r_presc <= r_presc + 1'b1;
    end
  end

  // Blink phase toggles every BLINK_FRAMES frames
  always_ff @(posedge Clk or negedge reset) begin
    if (!reset) begin
      r_blink_cnt   <= '0;
      r_blink_phase <= 1'b0;
    end else if (w_frame_end) begin
      if (r_blink_cnt == BLINK_LAST) begin
        r_blink_cnt   <= '0;
        r_blink_phase <= ~r_blink_phase;
      end else begin
        r_blink_cnt <= r_blink_cnt + 1'b1;
      end
    end
  end

  // FSM: state register
  always_ff @(posedge Clk or negedge reset) begin
    if (!reset) r_state <= ST_NORMAL;
    else        r_state <= w_state_nxt;
  end

  // FSM: next state. Requests outside NORMAL are simply not looked at.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_NORMAL:   if (msg_req) w_state_nxt = ST_MSG_WAIT;
      ST_MSG_WAIT: if (w_frame_end) w_state_nxt = ST_MSG_SHOW;
      ST_MSG_SHOW: if (w_frame_end && (r_msg_cnt == MSG_LAST)) w_state_nxt = ST_NORMAL;
      default:     w_state_nxt = ST_NORMAL;
    endcase
  end

  // FSM: outputs
  always_comb begin
    w_busy     = (r_state != ST_NORMAL);
    w_accept   = (r_state == ST_NORMAL) && msg_req;
    w_show_msg = (r_state == ST_MSG_SHOW);
  end

  // Message frame counter is held at 0 while waiting so the show always
  // starts from a clean count.
  always_ff @(posedge Clk or negedge reset) begin
    if (!reset) begin
      r_msg_cnt <= '0;
    end else if (r_state == ST_MSG_WAIT) begin
      r_msg_cnt <= '0;
    end else if (w_show_msg && w_frame_end) begin
      r_msg_cnt <= (r_msg_cnt == MSG_LAST) ? '0 : r_msg_cnt + 1'b1;
    end
  end

  // Message latch and acknowledge
  always_ff @(posedge Clk or negedge reset) begin
    if (!reset) begin
      r_ack      <= 1'b0;
      r_msg_data <= '0;
      r_msg_en   <= '0;
    end else begin
      r_ack <= w_accept;
      if (w_accept) begin
        r_msg_data <= msg_data;
        r_msg_en   <= msg_en;
      end
    end
  end

  // Source mux and digit select; blinking applies only to the normal source
  assign w_src_data = w_show_msg ? r_msg_data : norm_data;
  assign w_src_en   = w_show_msg ? r_msg_en   : norm_en;
  assign w_nib      = w_src_data[{r_digit, 2'b00} +: 4];
  assign w_blank    = !w_src_en[r_digit] ||
                      (!w_show_msg && norm_blink[r_digit] && r_blink_phase);

  hex_to_ssd u_hex (
    .i_nib  (w_nib),
    .o_cath (w_hex)
  );

  // Registered display drive
  always_ff @(posedge Clk or negedge reset) begin
    if (!reset) begin
      r_an   <= AN_OFF;
      r_cath <= CATH_BLANK;
    end else if (w_blank) begin
      r_an   <= AN_OFF;
      r_cath <= CATH_BLANK;
    end else begin
      r_an   <= ~(8'd1 << r_digit);
      r_cath <= w_hex;
    end
  end

  assign msg_ack   = r_ack;
  assign msg_busy  = w_busy;
  assign digit_idx = r_digit;
  assign An        = r_an;
  assign Cath      = r_cath;
  assign Dp        = 1'b1;

endmodule

// File: tb/tb_ssd_scan_arbiter.sv
module tb_ssd_scan_arbiter;

  logic        Clk = 1'b0;
  logic        reset;
  logic [31:0] norm_data;
  logic [7:0]  norm_en;
  logic [7:0]  norm_blink;
  logic        msg_req;
  logic [31:0] msg_data;
  logic [7:0]  msg_en;
  logic        msg_ack;
  logic        msg_busy;
  logic [2:0]  digit_idx;
  logic [7:0]  An;
  logic [6:0]  Cath;
  logic        Dp;

  int checks = 0;
  int errors = 0;

  ssd_scan_arbiter #(
    .SCAN_DIV     (4),
    .BLINK_FRAMES (2),
    .MSG_FRAMES   (3)
  ) dut (
    .Clk        (Clk),
    .reset      (reset),
    .norm_data  (norm_data),
    .norm_en    (norm_en),
    .norm_blink (norm_blink),
    .msg_req    (msg_req),
    .msg_data   (msg_data),
    .msg_en     (msg_en),
    .msg_ack    (msg_ack),
    .msg_busy   (msg_busy),
    .digit_idx  (digit_idx),
    .An         (An),
    .Cath       (Cath),
    .Dp         (Dp)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    logic [31:0] data;
    logic [7:0]  en;
    logic [2:0]  dig;
    logic [7:0]  an;
    logic [6:0]  cath;
  } vec_t;

  vec_t tbl [15];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge Clk);
  endtask

  // Lands on the first negedge of a fresh scan slot for digit d.
  task automatic wait_digit(input logic [2:0] d);
    int k;
    k = 0;
    while (digit_idx === d && k < 200) begin @(negedge Clk); k++; end
    while (digit_idx !== d && k < 200) begin @(negedge Clk); k++; end
    if (digit_idx !== d) begin
      checks++;
      errors++;
      $display("FAIL wait_digit: got %0d expected %0d (timeout)", digit_idx, d);
    end
  endtask

  task automatic do_reset();
    reset = 1'b0;
    tick(2);
    reset = 1'b1;
  endtask

  int nack, nbusy_lo;

  initial begin
    tbl[0]  = '{32'h76543210, 8'hFF, 3'd0, 8'hFE, 7'b0000001};
    tbl[1]  = '{32'h76543210, 8'hFF, 3'd3, 8'hF7, 7'b0000110};
    tbl[2]  = '{32'h76543210, 8'hFF, 3'd5, 8'hDF, 7'b0100100};
    tbl[3]  = '{32'h76543210, 8'hFF, 3'd7, 8'h7F, 7'b0001111};
    tbl[4]  = '{32'h76543210, 8'hDF, 3'd5, 8'hFF, 7'h7F};
    tbl[5]  = '{32'h76543210, 8'hDF, 3'd4, 8'hEF, 7'b1001100};
    tbl[6]  = '{32'hFEDCBA98, 8'hFF, 3'd0, 8'hFE, 7'b0000000};
    tbl[7]  = '{32'hFEDCBA98, 8'hFF, 3'd1, 8'hFD, 7'b0000100};
    tbl[8]  = '{32'hFEDCBA98, 8'hFF, 3'd2, 8'hFB, 7'b0001000};
    tbl[9]  = '{32'hFEDCBA98, 8'hFF, 3'd3, 8'hF7, 7'b1100000};
    tbl[10] = '{32'hFEDCBA98, 8'hFF, 3'd4, 8'hEF, 7'b0110001};
    tbl[11] = '{32'hFEDCBA98, 8'hFF, 3'd5, 8'hDF, 7'b1000010};
    tbl[12] = '{32'hFEDCBA98, 8'hFF, 3'd6, 8'hBF, 7'b0110000};
    tbl[13] = '{32'hFEDCBA98, 8'hFF, 3'd7, 8'h7F, 7'b0111000};
    tbl[14] = '{32'hFEDCBA98, 8'h00, 3'd2, 8'hFF, 7'h7F};

    reset      = 1'b0;
    norm_data  = 32'h76543210;
    norm_en    = 8'hFF;
    norm_blink = 8'h00;
    msg_req    = 1'b0;
    msg_data   = 32'h0;
    msg_en     = 8'hFF;

    // Reset values
    tick(2);
    chk("rst_an", An, 8'hFF);
    chk("rst_cath", Cath, 7'h7F);
    chk("rst_dp", Dp, 1'b1);
    chk("rst_busy", msg_busy, 1'b0);
    chk("rst_ack", msg_ack, 1'b0);
    chk("rst_digit", digit_idx, 3'd0);

    // Release and scan timing
    reset = 1'b1;
    tick(1);
    chk("rel_an", An, 8'hFE);
    chk("rel_cath", Cath, 7'b0000001);
    chk("rel_digit", digit_idx, 3'd0);
    tick(2);
    chk("digit_hold", digit_idx, 3'd0);
    tick(1);
    chk("digit_adv1", digit_idx, 3'd1);
    tick(4);
    chk("digit_adv2", digit_idx, 3'd2);

    // Table-driven digit/enable/decode vectors
    for (int i = 0; i < 15; i++) begin
      norm_data = tbl[i].data;
      norm_en   = tbl[i].en;
      wait_digit(tbl[i].dig);
      tick(1);
      chk($sformatf("tbl%0d_an", i), An, tbl[i].an);
      chk($sformatf("tbl%0d_cath", i), Cath, tbl[i].cath);
    end

    // Blink: digit 0 shown 2 frames, blanked 2 frames
    norm_data  = 32'h76543210;
    norm_en    = 8'hFF;
    norm_blink = 8'h01;
    do_reset();
    tick(1);
    chk("blink_f0", An, 8'hFE);
    tick(32);
    chk("blink_f1", An, 8'hFE);
    tick(32);
    chk("blink_f2_an", An, 8'hFF);
    chk("blink_f2_cath", Cath, 7'h7F);
    tick(4);
    chk("blink_f2_d1_an", An, 8'hFD);
    chk("blink_f2_d1_cath", Cath, 7'b1001111);
    tick(28);
    chk("blink_f3", An, 8'hFF);
    tick(32);
    chk("blink_f4", An, 8'hFE);

    // Message: request at digit 3
    norm_blink = 8'h00;
    do_reset();
    wait_digit(3'd3);
    msg_req  = 1'b1;
    msg_data = 32'hFEDCBA98;
    msg_en   = 8'hFF;
    tick(1);
    chk("msg_ack", msg_ack, 1'b1);
    chk("msg_busy", msg_busy, 1'b1);
    msg_req = 1'b0;
    tick(1);
    chk("msg_ack_pulse", msg_ack, 1'b0);
    wait_digit(3'd7);
    tick(1);
    chk("wait_norm_cath", Cath, 7'b0001111);
    wait_digit(3'd0);
    chk("wrap_busy", msg_busy, 1'b1);
    tick(1);
    chk("show_an", An, 8'hFE);
    chk("show_cath", Cath, 7'b0000000);
    // Second request held during show
    tick(9);
    msg_req  = 1'b1;
    msg_data = 32'h11111111;
    nack     = 0;
    nbusy_lo = 0;
    for (int i = 0; i < 85; i++) begin
      tick(1);
      if (msg_ack) nack++;
      if (!msg_busy) nbusy_lo++;
    end
    chk("show_no_ack", nack, 0);
    chk("show_busy_hold", nbusy_lo, 0);
    chk("show_last_cath", Cath, 7'b0111000);
    tick(1);
    chk("ret_busy", msg_busy, 1'b0);
    chk("ret_ack", msg_ack, 1'b0);
    tick(1);
    chk("req2_ack", msg_ack, 1'b1);
    chk("req2_busy", msg_busy, 1'b1);
    chk("ret_norm_an", An, 8'hFE);
    chk("ret_norm_cath", Cath, 7'b0000001);
    msg_req = 1'b0;
    wait_digit(3'd0);
    tick(1);
    chk("show2_cath", Cath, 7'b1001111);

    // Asynchronous reset during show
    tick(3);
    #2 reset = 1'b0;
    #1;
    chk("arst_an", An, 8'hFF);
    chk("arst_cath", Cath, 7'h7F);
    chk("arst_busy", msg_busy, 1'b0);
    chk("arst_digit", digit_idx, 3'd0);
    @(negedge Clk);
    reset = 1'b1;
    tick(1);
    chk("post_an", An, 8'hFE);
    chk("post_cath", Cath, 7'b0000001);
    chk("post_busy", msg_busy, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
